// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// -----------------------------------------------------------------------------
// Frame-level asynchronous serial transmitter. One parallel word is accepted
// per handshake. It is sent on an idle-high line as: start bit (0), data bits
// LSB first, an optional even-parity bit, and a stop bit (1).
//
// The datapath is a parallel-to-serial shift register paced by a bit-period
// timer. A five-state FSM (IDLE, START, DATA, PARITY, STOP) sequences the frame.
// The FSM is split into a state register and a combinational next-state block.
// All outputs are registered.
//
// Parameters
//   DATA_BITS     data bits per frame (5..9)
//   CLKS_PER_BIT  clock cycles per serial bit period (>= 1)
//   PARITY_EN     1 inserts an even-parity bit after the data bits
//
// Ports
//   clk         in   system clock, rising edge
//   n_rst       in   asynchronous active-low reset
//   tx_data     in   word to send, sampled only on the accepting edge
//   tx_start    in   request, accepted on an edge where tx_busy is 0
//   tx_busy     out  high while a frame is in flight
//   tx_done     out  one-cycle pulse after the stop bit completes
//   serial_out  out  serial line, idle high
// -----------------------------------------------------------------------------
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 10,
  parameter int PARITY_EN    = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_start,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic                 serial_out
);

  localparam int TW = $clog2(CLKS_PER_BIT + 1);
  localparam int BW = $clog2(DATA_BITS + 1);

  // Terminal counts for the bit-period timer and the data-bit counter.
  localparam logic [TW-1:0] LAST_TICK  = TW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
  localparam bit            HAS_PARITY = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // The even-parity bit is the XOR of the data bits. With that bit added,
  // the total count of ones in the frame is even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] word);
    even_parity = ^word;
  endfunction

  state_t                 state_r,    state_nxt_s;
  logic [TW-1:0]          timer_r,    timer_nxt_s;
  logic [BW-1:0]          bit_cnt_r,  bit_cnt_nxt_s;
  logic [DATA_BITS-1:0]   shift_r,    shift_nxt_s;
  logic                   parity_r,   parity_nxt_s;
  logic                   serial_r,   serial_nxt_s;
  logic                   busy_r,     busy_nxt_s;
  logic                   done_r,     done_nxt_s;
  logic                   bit_end_s;

  // A bit period ends on the edge where the timer holds its last count.
  // With CLKS_PER_BIT = 1 this is true on every cycle, so each bit lasts
  // exactly one clock.
  assign bit_end_s = (timer_r == LAST_TICK);

  // State, datapath and output registers. An asserted reset abandons any
  // frame immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r   <= IDLE;
      timer_r   <= '0;
      bit_cnt_r <= '0;
      shift_r   <= '0;
      parity_r  <= 1'b0;
      serial_r  <= 1'b1;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      timer_r   <= timer_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      parity_r  <= parity_nxt_s;
      serial_r  <= serial_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

  // Next-state logic. The serial level is computed for the cycle that follows,
  // so the registered line changes on the same edge as the state. Accepting a
  // request therefore puts the start bit on the line with no extra cycle.
  always_comb begin
    state_nxt_s   = state_r;
    timer_nxt_s   = timer_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    parity_nxt_s  = parity_r;
    serial_nxt_s  = serial_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;

    // The timer runs in every non-idle state. It clears at each bit boundary.
    if (state_r != IDLE) begin
      if (bit_end_s) begin
        timer_nxt_s = '0;
      end else begin
        timer_nxt_s = timer_r + TW'(1);
      end
    end else begin
      timer_nxt_s = '0;
    end

    case (state_r)
      IDLE: begin
        serial_nxt_s = 1'b1;
        busy_nxt_s   = 1'b0;
        if (tx_start) begin
          state_nxt_s   = START;
          shift_nxt_s   = tx_data;
          parity_nxt_s  = even_parity(tx_data);
          bit_cnt_nxt_s = '0;
          serial_nxt_s  = 1'b0;
          busy_nxt_s    = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          state_nxt_s  = DATA;
          serial_nxt_s = shift_r[0];
        end else begin
          serial_nxt_s = 1'b0;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_nxt_s = '0;
            if (HAS_PARITY) begin
              state_nxt_s  = PARITY;
              serial_nxt_s = parity_r;
            end else begin
              state_nxt_s  = STOP;
              serial_nxt_s = 1'b1;
            end
          end else begin
            // The next data bit is shift_r[1]. It moves into bit 0 on this edge.
            shift_nxt_s   = {1'b0, shift_r[DATA_BITS-1:1]};
            bit_cnt_nxt_s = bit_cnt_r + BW'(1);
            serial_nxt_s  = shift_r[1];
          end
        end else begin
          serial_nxt_s = shift_r[0];
        end
      end

      PARITY: begin
        if (bit_end_s) begin
          state_nxt_s  = STOP;
          serial_nxt_s = 1'b1;
        end else begin
          serial_nxt_s = parity_r;
        end
      end

      STOP: begin
        serial_nxt_s = 1'b1;
        if (bit_end_s) begin
          state_nxt_s = IDLE;
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
        end else begin
          busy_nxt_s = 1'b1;
        end
      end

      default: begin
        // Unreachable encoding. Fall back to a clean idle line.
        state_nxt_s   = IDLE;
        timer_nxt_s   = '0;
        bit_cnt_nxt_s = '0;
        serial_nxt_s  = 1'b1;
        busy_nxt_s    = 1'b0;
      end
    endcase
  end

  assign tx_busy    = busy_r;
  assign tx_done    = done_r;
  assign serial_out = serial_r;

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Frame-level serial transmitter; the transmit-side counterpart to the team's serial-to-parallel receive path. Accepts one parallel data word per handshake and drives it onto a single idle-high line as an asynchronous serial frame: start bit, data LSB first, optional even parity, stop bit. Internally it is a parallel-to-serial shift register (LSB out first) paced by a bit-period timer and a small FSM. Sits between the byte-producing logic and the physical serial output pin.

## Interface
- DATA_BITS, 8, number of data bits per frame (legal 5..9)
- CLKS_PER_BIT, 10, clock cycles per serial bit period (legal >= 1)
- PARITY_EN, 0, 1 inserts an even-parity bit after the data bits; 0 omits it

- clk  input  1  system clock, all state on rising edge
- n_rst  input  1  reset; one clock; reset is asynchronous and active-low
- tx_data  input  DATA_BITS  word to send; sampled only on the accepting edge
- tx_start  input  1  request; accepted on a rising edge where tx_busy is 0
- tx_busy  output  1  high while a frame is being transmitted
- tx_done  output  1  one-cycle pulse when a frame's stop bit completes
- serial_out  output  1  serial line, idle high

## Operation
- Reset values: serial_out=1, tx_busy=0, tx_done=0, FSM=IDLE, timer and bit counter 0, shift register 0.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: serial_out=1. If tx_start=1 at an edge: load tx_data into shift register, compute parity = XOR of tx_data bits (even parity: parity bit makes total ones even), go to START.
- START: serial_out=0 for CLKS_PER_BIT cycles, then DATA.
- DATA: serial_out = shift register bit 0; after each CLKS_PER_BIT cycles shift right by one; after DATA_BITS bit periods go to PARITY if PARITY_EN=1, else STOP.
- PARITY: serial_out = stored parity bit for CLKS_PER_BIT cycles, then STOP.
- STOP: serial_out=1 for CLKS_PER_BIT cycles, then IDLE with tx_done pulsed.
- Timer counts 0..CLKS_PER_BIT-1 and clears at every bit boundary; width $clog2(CLKS_PER_BIT+1). Bit counter width $clog2(DATA_BITS+1).
- tx_start while tx_busy=1 is ignored (no queueing). tx_data changes while busy do not affect the frame in flight.
- tx_busy = (state != IDLE), registered consistently with state.
- n_rst asserted mid-frame: outputs return to reset values immediately; frame is abandoned, no tx_done.

## Timing
- Let N = 2 + DATA_BITS + PARITY_EN, C = CLKS_PER_BIT. tx_start accepted at edge k.
- After edge k: tx_busy=1, serial_out=0 (start bit), no extra latency cycle.
- Frame bit i (0=start) is on serial_out from after edge k+i*C through edge k+(i+1)*C.
- After edge k+N*C: state IDLE, tx_busy=0, tx_done=1 for exactly one cycle, serial_out=1.
- Back-to-back: tx_start=1 at edge k+N*C+1 (first edge with tx_busy=0, tx_done=1) is accepted; minimum frame spacing is N*C+1 cycles, i.e. at least one idle-high cycle after the stop bit.
- C=1: each bit lasts one cycle; timer logic must not stall or skip bits.
- tx_done never asserts while tx_busy=1 and never on two consecutive cycles.

## Test plan
- Reset: assert n_rst=0 with tx_start=1 -> serial_out=1, tx_busy=0, tx_done=0 throughout; release -> no frame starts until tx_start sampled with n_rst=1.
- Defaults, tx_data=0xA5 -> serial_out sequence 0,1,0,1,0,0,1,0,1,1, each held 10 cycles; tx_busy high 100 cycles; tx_done pulse after edge k+100.
- PARITY_EN=1, tx_data=0x07 -> data 1,1,1,0,0,0,0,0 then parity 1 then stop 1; frame 110 cycles; 0x03 -> parity bit 0.
- Busy rules: pulse tx_start and change tx_data to 0xFF at cycle 30 of a 0x00 frame -> frame remains all-zero data, no second frame; then tx_start on the tx_done cycle edge -> second frame starts with exactly one idle-high cycle gap.
- Reset mid-frame: n_rst=0 at cycle 45 of a frame -> serial_out=1, tx_busy=0 asynchronously, no tx_done; next frame after release is bit-exact.
- CLKS_PER_BIT=1, DATA_BITS=5, tx_data=5'b10110 -> serial_out 0,0,1,1,0,1,1 on consecutive cycles, tx_done after edge k+7.
